sign_narrow: RTL

- Inverse of the immediate sign-extension path: takes a 32-bit two's-complement value and narrows it to a 17-bit signed field, e.g. for packing immediates or store-offset fields.
- Flags values that do not fit in 17 bits and keeps overflow statistics.
- Two-stage valid/ready pipeline between the ALU/writeback side and the field packer.

---
 rtl/sign_pkg.sv | 15 +
 rtl/sign_narrow_fit.sv | 29 ++
 rtl/sign_narrow.sv | 95 +++++++++
 3 files changed

// File: rtl/sign_pkg.sv
// Shared constants and types for narrowing 32-bit words to the 17-bit immediate field.
package sign_pkg;

  localparam int IMM_W  = 17;
  localparam int WORD_W = 32;

  localparam logic [IMM_W-1:0] SAT_MAX = {1'b0, {(IMM_W-1){1'b1}}};
  localparam logic [IMM_W-1:0] SAT_MIN = {1'b1, {(IMM_W-1){1'b0}}};

  typedef struct packed {
    logic [IMM_W-1:0] data;
    logic             ovf;
  } narrow_res_t;

endpackage

// File: rtl/sign_narrow_fit.sv
// Combinational fit check and narrowing select; saturates on overflow when
// SIGN_NARROW_SAT_EN is defined, otherwise truncates.
module sign_narrow_fit
  import sign_pkg::*;
#(
  parameter int W_IN  = WORD_W,
  parameter int W_OUT = IMM_W
) (
  input  logic [W_IN-1:0]  data,
  output logic [W_OUT-1:0] res_data,
  output logic             res_ovf
);

  logic fit;

  // The value fits when every bit from the MSB down to the new sign bit agrees.
  assign fit     = (&data[W_IN-1:W_OUT-1]) | ~(|data[W_IN-1:W_OUT-1]);
  assign res_ovf = ~fit;

`ifdef SIGN_NARROW_SAT_EN
  localparam logic [W_OUT-1:0] MAX_POS = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic [W_OUT-1:0] MIN_NEG = {1'b1, {(W_OUT-1){1'b0}}};

  assign res_data = fit ? data[W_OUT-1:0] : (data[W_IN-1] ? MIN_NEG : MAX_POS);
`else
  assign res_data = data[W_OUT-1:0];
`endif

endmodule

// File: rtl/sign_narrow.sv
// Two-stage valid/ready pipeline narrowing a signed word to a signed field, with
// overflow flag and statistics. Optional saturation via SIGN_NARROW_SAT_EN.
module sign_narrow
  import sign_pkg::*;
#(
  parameter int W_IN  = WORD_W,
  parameter int W_OUT = IMM_W,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             stat_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid;
  logic [W_IN-1:0]  s1_data;
  logic             s2_valid;
  logic [W_OUT-1:0] s2_data;
  logic             s2_ovf;
  logic             s1_adv;
  logic             s2_adv;
  logic [W_OUT-1:0] fit_data;
  logic             fit_ovf;
  logic             ovf_event;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = s2_adv | ~s1_valid;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_ovf   = s2_ovf;
  assign ovf_event = s2_valid & out_ready & s2_ovf;

  sign_narrow_fit #(
    .W_IN  (W_IN),
    .W_OUT (W_OUT)
  ) u_fit (
    .data     (s1_data),
    .res_data (fit_data),
    .res_ovf  (fit_ovf)
  );

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its upstream stage, giving true pipeline behaviour.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= fit_data;
        s2_ovf  <= fit_ovf;
      end
    end
  end

  // A clear coinciding with an overflow delivery leaves exactly that one event counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (ovf_event) begin
      ovf_sticky <= 1'b1;
      if (stat_clr)                ovf_count <= CNT_W'(1);
      else if (ovf_count != CNT_MAX) ovf_count <= ovf_count + CNT_W'(1);
    end else if (stat_clr) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule
